interp_sample_reader: RTL and testbench

//  Reader side of the sample-index path in the interpolation datapath: it walks a stored row with a 4-bit index advanced by a step.
//  - Accepts one row of N_SAMPLES reference samples through a valid/ready load port.
//  - Streams TAPS-wide sample windows to the interpolation filter, one window per accepted handshake.
//  - The window start index begins at 0 and advances by a latched step until the row is exhausted.

---
 rtl/interp_pkg.sv | 15 +
 rtl/interp_sample_reader_if.sv | 30 +++
 rtl/interp_window_mux.sv | 24 ++
 rtl/interp_sample_reader.sv | 79 +++++++
 tb/tb_interp_sample_reader.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/interp_pkg.sv
// Shared constants and state encoding for the interpolation sample reader.
// The default geometry is one 16-sample row read through an 8-tap window.
package interp_pkg;

    localparam int DATA_W    = 8;
    localparam int N_SAMPLES = 16;
    localparam int TAPS      = 8;
    localparam int IDX_W     = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

endpackage

// File: rtl/interp_sample_reader_if.sv
// Row-load and window-stream signals of the sample reader, bundled into one interface.
// Handshake: a transfer happens on a rising edge where valid && ready; valid is never withdrawn
// before its transfer, and the payload stays stable while valid is high and ready is low.
interface interp_sample_reader_if #(
    parameter int DATA_W    = interp_pkg::DATA_W,
    parameter int N_SAMPLES = interp_pkg::N_SAMPLES,
    parameter int TAPS      = interp_pkg::TAPS
);
    logic                          row_valid;
    logic                          row_ready;
    logic [N_SAMPLES*DATA_W-1:0]   row_data;
    logic [interp_pkg::IDX_W-1:0]  row_step;
    logic                          win_valid;
    logic                          win_ready;
    logic [TAPS*DATA_W-1:0]        win_data;
    logic [interp_pkg::IDX_W-1:0]  win_idx;
    logic                          win_last;

    // master: row producer and window consumer
    modport master (
        output row_valid, row_data, row_step, win_ready,
        input  row_ready, win_valid, win_data, win_idx, win_last
    );

    // slave: the reader itself
    modport slave (
        input  row_valid, row_data, row_step, win_ready,
        output row_ready, win_valid, win_data, win_idx, win_last
    );
endinterface

// File: rtl/interp_window_mux.sv
// Combinational window selector: picks TAPS consecutive samples starting at i_idx.
// Taps that would fall past the end of the row read as zero; the reader never issues such an index.
module interp_window_mux
    import interp_pkg::*;
#(
    parameter int P_DATA_W    = DATA_W,
    parameter int P_N_SAMPLES = N_SAMPLES,
    parameter int P_TAPS      = TAPS
) (
    input  logic [P_N_SAMPLES*P_DATA_W-1:0] i_row,
    input  logic [IDX_W-1:0]                i_idx,
    output logic [P_TAPS*P_DATA_W-1:0]      o_win
);

    always_comb begin
        o_win = '0;
        for (int j = 0; j < P_TAPS; j++) begin
            if (int'(i_idx) + j < P_N_SAMPLES) begin
                o_win[j*P_DATA_W +: P_DATA_W] = i_row[(int'(i_idx) + j)*P_DATA_W +: P_DATA_W];
            end
        end
    end

endmodule

// File: rtl/interp_sample_reader.sv
// Sample reader: latches one row and a step, then streams TAPS-wide windows whose start
// index advances by the step until the next start would run past the end of the row.
module interp_sample_reader
    import interp_pkg::*;
#(
    parameter int P_DATA_W    = DATA_W,
    parameter int P_N_SAMPLES = N_SAMPLES,
    parameter int P_TAPS      = TAPS
) (
    input  logic                    clk,
    input  logic                    rst_n,
    interp_sample_reader_if.slave   rd_bus,
    output state_t                  o_dbg_state
);

    localparam logic [IDX_W:0] LAST_START = (IDX_W+1)'(P_N_SAMPLES - P_TAPS);

    state_t                          r_state;
    logic [P_N_SAMPLES*P_DATA_W-1:0] r_row;
    logic [IDX_W-1:0]                r_step;
    logic [IDX_W-1:0]                r_idx;

    logic [IDX_W:0]                  w_nxt;
    logic                            w_last;
    logic [P_TAPS*P_DATA_W-1:0]      w_window;

    // One extra bit keeps idx+step from wrapping back into the valid range.
    assign w_nxt  = {1'b0, r_idx} + {1'b0, r_step};
    assign w_last = (w_nxt > LAST_START);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_row   <= '0;
            r_step  <= '0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (rd_bus.row_valid) begin
                        r_row   <= rd_bus.row_data;
                        r_step  <= (rd_bus.row_step == '0) ? IDX_W'(1) : rd_bus.row_step;
                        r_idx   <= '0;
                        r_state <= STREAM;
                    end
                end
                STREAM: begin
                    if (rd_bus.win_ready) begin
                        if (w_last) begin
                            r_idx   <= '0;
                            r_state <= IDLE;
                        end else begin
                            r_idx   <= w_nxt[IDX_W-1:0];
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    interp_window_mux #(
        .P_DATA_W    (P_DATA_W),
        .P_N_SAMPLES (P_N_SAMPLES),
        .P_TAPS      (P_TAPS)
    ) u_window_mux (
        .i_row (r_row),
        .i_idx (r_idx),
        .o_win (w_window)
    );

    assign rd_bus.row_ready = (r_state == IDLE);
    assign rd_bus.win_valid = (r_state == STREAM);
    assign rd_bus.win_data  = w_window;
    assign rd_bus.win_idx   = r_idx;
    assign rd_bus.win_last  = (r_state == STREAM) && w_last;
    assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_interp_sample_reader.sv
// Bench for interp_sample_reader: table of step cases plus hand-written corner sequences,
// with a queue-based scoreboard fed by a window-list model of each loaded row.
module tb_interp_sample_reader;
    import interp_pkg::*;

    localparam int W  = 8;
    localparam int N  = 16;
    localparam int T  = 8;
    localparam int XW = 1 + IDX_W + T*W;

    typedef struct {
        logic [3:0] step;
        int         n_win;
        logic [3:0] last_idx;
        bit         rand_ready;
    } vec_t;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    state_t dbg_state;
    state_t dbg_state16;

    always #5 clk = ~clk;

    interp_sample_reader_if #(.DATA_W(W), .N_SAMPLES(N), .TAPS(T))  bus   ();
    interp_sample_reader_if #(.DATA_W(W), .N_SAMPLES(N), .TAPS(N))  bus16 ();

    interp_sample_reader #(.P_DATA_W(W), .P_N_SAMPLES(N), .P_TAPS(T)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_bus      (bus.slave),
        .o_dbg_state (dbg_state)
    );

    interp_sample_reader #(.P_DATA_W(W), .P_N_SAMPLES(N), .P_TAPS(N)) dut16 (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_bus      (bus16.slave),
        .o_dbg_state (dbg_state16)
    );

    int              n_checks = 0;
    int              n_fail   = 0;
    logic [XW-1:0]   exp_q[$];
    int              n_hs = 0;
    logic [3:0]      last_hs_idx = '0;
    logic            prev_stall = 1'b0;
    logic [XW-1:0]   prev_val = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: every start index 0, s, 2s, ... that still fits a full window, last flagged.
    task automatic push_row(input logic [N*W-1:0] row, input logic [3:0] step);
        int            s;
        logic [T*W-1:0] win;
        s = (step == 4'd0) ? 1 : int'(step);
        for (int i = 0; i <= N - T; i += s) begin
            for (int j = 0; j < T; j++) win[j*W +: W] = row[(i+j)*W +: W];
            exp_q.push_back({(i + s > N - T), 4'(i), win});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_row(output logic [N*W-1:0] row);
        for (int k = 0; k < N; k++) row[k*W +: W] = 8'($urandom);
    endtask

    task automatic load_row(input logic [N*W-1:0] row, input logic [3:0] step);
        int k = 0;
        while (!bus.row_ready && k < 100) begin
            tick();
            k++;
        end
        check("row_ready_wait", bus.row_ready, 1);
        bus.row_valid = 1'b1;
        bus.row_data  = row;
        bus.row_step  = step;
        push_row(row, step);
        tick();
        bus.row_valid = 1'b0;
    endtask

    task automatic drain(input bit rand_ready);
        int k = 0;
        while (exp_q.size() > 0 && k < 500) begin
            bus.win_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            k++;
        end
        check("drain_empty", exp_q.size(), 0);
        check("turnaround_row_ready", bus.row_ready, 1);
        check("turnaround_win_valid", bus.win_valid, 0);
        bus.win_ready = 1'b0;
    endtask

    // Scoreboard and stability monitor, sampled mid-cycle.
    always @(negedge clk) begin : monitor
        logic [XW-1:0] act;
        act = {bus.win_last, bus.win_idx, bus.win_data};
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("valid_held", bus.win_valid, 1);
                check("hold_stable", act, prev_val);
            end
            if (bus.win_valid && bus.win_ready) begin
                n_hs++;
                last_hs_idx = bus.win_idx;
                check("window_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) check("window", act, exp_q.pop_front());
            end
            prev_stall = bus.win_valid && !bus.win_ready;
            prev_val   = act;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t              vecs[9];
        logic [N*W-1:0]    row_a;
        logic [N*W-1:0]    row_b;
        logic [N*W-1:0]    row16;
        int                h0;
        int                k;

        vecs[0] = '{4'd1,  9, 4'd8, 1'b0};
        vecs[1] = '{4'd3,  3, 4'd6, 1'b0};
        vecs[2] = '{4'd0,  9, 4'd8, 1'b0};
        vecs[3] = '{4'd2,  5, 4'd8, 1'b1};
        vecs[4] = '{4'd4,  3, 4'd8, 1'b1};
        vecs[5] = '{4'd5,  2, 4'd5, 1'b0};
        vecs[6] = '{4'd8,  2, 4'd8, 1'b1};
        vecs[7] = '{4'd9,  1, 4'd0, 1'b0};
        vecs[8] = '{4'd15, 1, 4'd0, 1'b1};

        bus.row_valid   = 1'b0;
        bus.row_data    = '0;
        bus.row_step    = '0;
        bus.win_ready   = 1'b0;
        bus16.row_valid = 1'b0;
        bus16.row_data  = '0;
        bus16.row_step  = '0;
        bus16.win_ready = 1'b0;

        // Reset values
        #1;
        check("rst_state", dbg_state, IDLE);
        check("rst_row_ready", bus.row_ready, 1);
        check("rst_win_valid", bus.win_valid, 0);
        check("rst_win_idx", bus.win_idx, 0);
        check("rst_win_last", bus.win_last, 0);
        check("rst_win_data", bus.win_data, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Ramp row, step 1: nine windows
        for (int i = 0; i < N; i++) row_a[i*W +: W] = 8'(i);
        h0 = n_hs;
        load_row(row_a, 4'd1);
        check("first_valid", bus.win_valid, 1);
        check("first_idx", bus.win_idx, 0);
        check("first_last", bus.win_last, 0);
        check("first_row_ready", bus.row_ready, 0);
        drain(1'b0);
        check("ramp_count", n_hs - h0, 9);
        check("ramp_last_idx", last_hs_idx, 8);

        // Step table with random rows
        for (int v = 0; v < 9; v++) begin
            rand_row(row_a);
            h0 = n_hs;
            load_row(row_a, vecs[v].step);
            drain(vecs[v].rand_ready);
            check("table_count", n_hs - h0, vecs[v].n_win);
            check("table_last_idx", last_hs_idx, vecs[v].last_idx);
        end

        // Backpressure 1,0,0,1 with a competing row offered mid-stream
        rand_row(row_a);
        rand_row(row_b);
        load_row(row_a, 4'd2);
        bus.row_valid = 1'b1;
        bus.row_data  = row_b;
        bus.row_step  = 4'd1;
        bus.win_ready = 1'b1;
        tick();
        check("bp_row_ready", bus.row_ready, 0);
        check("bp_idx_a", bus.win_idx, 2);
        bus.win_ready = 1'b0;
        tick();
        check("bp_idx_b", bus.win_idx, 2);
        tick();
        check("bp_idx_c", bus.win_idx, 2);
        check("bp_row_ready2", bus.row_ready, 0);
        bus.win_ready = 1'b1;
        tick();
        check("bp_idx_d", bus.win_idx, 4);
        bus.row_valid = 1'b0;
        drain(1'b0);

        // Asynchronous reset in the middle of a row
        rand_row(row_a);
        load_row(row_a, 4'd1);
        bus.win_ready = 1'b1;
        k = 0;
        while (bus.win_idx != 4'd5 && k < 50) begin
            tick();
            k++;
        end
        check("reach_idx5", bus.win_idx, 5);
        bus.win_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_state", dbg_state, IDLE);
        check("arst_row_ready", bus.row_ready, 1);
        check("arst_win_valid", bus.win_valid, 0);
        check("arst_win_idx", bus.win_idx, 0);
        check("arst_win_last", bus.win_last, 0);
        check("arst_win_data", bus.win_data, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        rand_row(row_a);
        load_row(row_a, 4'd1);
        check("restart_idx", bus.win_idx, 0);
        drain(1'b1);

        // Back-to-back rows with row_valid held high
        rand_row(row_a);
        rand_row(row_b);
        bus.row_valid = 1'b1;
        bus.row_data  = row_a;
        bus.row_step  = 4'd1;
        push_row(row_a, 4'd1);
        push_row(row_b, 4'd3);
        bus.win_ready = 1'b1;
        tick();
        bus.row_data = row_b;
        bus.row_step = 4'd3;
        k = 0;
        while (exp_q.size() > 3 && k < 100) begin
            tick();
            k++;
        end
        check("b2b_gap_ready", bus.row_ready, 1);
        check("b2b_gap_valid", bus.win_valid, 0);
        tick();
        check("b2b_second_valid", bus.win_valid, 1);
        check("b2b_second_idx", bus.win_idx, 0);
        check("b2b_second_data", bus.win_data, row_b[T*W-1:0]);
        check("b2b_row_ready", bus.row_ready, 0);
        bus.row_valid = 1'b0;
        drain(1'b0);

        // Window as wide as the row
        rand_row(row16);
        bus16.row_valid = 1'b1;
        bus16.row_data  = row16;
        bus16.row_step  = 4'd5;
        tick();
        bus16.row_valid = 1'b0;
        check("full_valid", bus16.win_valid, 1);
        check("full_idx", bus16.win_idx, 0);
        check("full_last", bus16.win_last, 1);
        check("full_data", bus16.win_data, row16);
        check("full_row_ready", bus16.row_ready, 0);
        bus16.win_ready = 1'b1;
        tick();
        bus16.win_ready = 1'b0;
        check("full_done_ready", bus16.row_ready, 1);
        check("full_done_valid", bus16.win_valid, 0);
        check("full_done_state", dbg_state16, IDLE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
